// File: rtl/alu_pkg.sv
// Shared definitions for the sequential multiply/divide engine.
// Provides the operation encodings, the FSM state encoding and the default
// operand width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mul_div_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   op       : OP_MUL selects a Booth step, OP_DIV a restoring-division step
//   acc      : 2*WIDTH+1 bit working accumulator
//   m        : multiplicand (multiply) or divisor magnitude (divide)
//   acc_next : accumulator after this iteration
// Multiply layout: {A[WIDTH-1:0], Q[WIDTH-1:0], q_minus1}.
// Divide layout:   {R[WIDTH:0], Q[WIDTH-1:0]}, R always < 2^WIDTH.
module seq_mul_div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               op,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   booth_hi;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    // Add/subtract in WIDTH+1 bits so that subtracting the most negative
    // multiplicand cannot overflow; the arithmetic shift then folds the
    // extra bit back into a WIDTH-bit A.
    booth_hi = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_ext    = {m[WIDTH-1], m};
    case (acc[1:0])
      2'b01:   booth_sum = booth_hi + m_ext;
      2'b10:   booth_sum = booth_hi - m_ext;
      default: booth_sum = booth_hi;
    endcase

    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, m};
    ge      = ~diff[WIDTH+1];

    if (op == OP_MUL) begin
      acc_next = {booth_sum, acc[WIDTH:1]};
    end else begin
      acc_next = {(ge ? diff[WIDTH:0] : shifted), acc[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative signed multiply/divide unit with a start/done handshake.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : request, accepted only in IDLE or DONE
//   op_sel         : OP_MUL (signed multiply) or OP_DIV (signed divide)
//   a, b           : operands, captured on the accepting edge
//   busy           : high while an operation is in flight
//   done           : one-cycle pulse when c is valid
//   div_by_zero    : last divide had b == 0, held with c
//   c              : product, or {remainder, quotient}
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one datapath iteration per clock
// FIX   | sign correction, result registered
// DONE  | result held, new start accepted
module seq_mul_div
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] c
);

  localparam int ITER = WIDTH;
  localparam int CW   = $clog2(ITER + 1);

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   a_reg;
  logic               op_reg, a_neg, b_neg, b_zero;
  logic               accept;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] c_fix;

  seq_mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_reg),
    .acc      (acc),
    .m        (m),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    accept     = start && (state == IDLE || state == DONE);
    state_next = state;
    case (state)
      IDLE, DONE: if (accept) state_next = RUN;
      RUN:        if (cnt == CW'(ITER - 1)) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    quo   = acc[WIDTH-1:0];
    rem   = acc[2*WIDTH-1:WIDTH];
    if (op_reg == OP_MUL) begin
      c_fix = acc[2*WIDTH:1];
    end else if (b_zero) begin
      c_fix = {a_reg, {WIDTH{1'b1}}};
    end else begin
      // Quotient truncates toward zero; remainder follows the dividend.
      c_fix = {(a_neg ? -rem : rem), ((a_neg ^ b_neg) ? -quo : quo)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      m           <= '0;
      a_reg       <= '0;
      op_reg      <= OP_MUL;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      b_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      c           <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_reg      <= op_sel;
        a_reg       <= a;
        a_neg       <= a[WIDTH-1];
        b_neg       <= b[WIDTH-1];
        b_zero      <= (b == '0);
        cnt         <= '0;
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
        if (op_sel == OP_MUL) begin
          acc <= {{WIDTH{1'b0}}, b, 1'b0};
          m   <= a;
        end else begin
          acc <= {{(WIDTH+1){1'b0}}, a_mag};
          m   <= b_mag;
        end
      end else if (state == RUN) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        c           <= c_fix;
        done        <= 1'b1;
        busy        <= 1'b0;
        div_by_zero <= (op_reg == OP_DIV) && b_zero;
      end
    end
  end

endmodule
